multi_led_blinker: RTL and testbench

Multi-channel successor to the single free-running LED blinker: drives `NUM_LEDS` outputs from one shared prescaler, each channel with its own mode (off, on, blink, dimmed blink), blink half-period and PWM duty. Software or a small controller writes per-channel configuration over a valid/ready port. Writes are applied on prescaler tick boundaries, so a channel changes without glitches. It sits directly between board-level LED pins and the configuration master.

---
 rtl/led_blink_pkg.sv | 18 +
 rtl/blink_channel.sv | 84 ++++++++
 rtl/multi_led_blinker.sv | 134 +++++++++++++
 tb/tb_multi_led_blinker.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_blink_pkg.sv
// Shared types and constants for the multi-channel LED blinker.
package led_blink_pkg;

  localparam int unsigned ModeW = 2;

  typedef enum logic [ModeW-1:0] {
    ModeOff      = 2'd0,
    ModeOn       = 2'd1,
    ModeBlink    = 2'd2,
    ModeBlinkDim = 2'd3
  } led_mode_t;

  typedef enum logic [0:0] {
    StIdle    = 1'b0,
    StPending = 1'b1
  } cfg_state_t;

endpackage

// File: rtl/blink_channel.sv
// One LED channel: holds its configuration, tick counter and blink phase,
// and produces the unregistered next LED value.
module blink_channel
  import led_blink_pkg::*;
#(
  parameter int unsigned PERIOD_W = 16,
  parameter int unsigned DUTY_W   = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                tick_i,
  input  logic [DUTY_W-1:0]   pwm_cnt_i,
  input  logic                load_i,
  input  led_mode_t           mode_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic [DUTY_W-1:0]   duty_i,
  output logic                led_next_o
);

  led_mode_t           mode_q, mode_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [DUTY_W-1:0]   duty_q, duty_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                phase_q, phase_d;

  logic [PERIOD_W-1:0] cnt_last;
  logic                pwm_on;

  // A half-period of 0 behaves like 1, so the last count is 0 in both cases.
  assign cnt_last = (period_q == '0) ? '0 : period_q - PERIOD_W'(1);
  assign pwm_on   = pwm_cnt_i < duty_q;

  // Next state: a load restarts the channel high; otherwise count ticks.
  always_comb begin
    mode_d   = mode_q;
    period_d = period_q;
    duty_d   = duty_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    if (load_i) begin
      mode_d   = mode_i;
      period_d = period_i;
      duty_d   = duty_i;
      cnt_d    = '0;
      phase_d  = 1'b1;
    end else if (tick_i) begin
      if (cnt_q == cnt_last) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + PERIOD_W'(1);
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q   <= ModeOff;
      period_q <= PERIOD_W'(1);
      duty_q   <= '0;
      cnt_q    <= '0;
      phase_q  <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
    end
  end

  // LED value selected by mode; registered by the top level.
  always_comb begin
    led_next_o = 1'b0;
    unique case (mode_q)
      ModeOff:      led_next_o = 1'b0;
      ModeOn:       led_next_o = 1'b1;
      ModeBlink:    led_next_o = phase_q;
      ModeBlinkDim: led_next_o = phase_q & pwm_on;
    endcase
  end

endmodule

// File: rtl/multi_led_blinker.sv
// Multi-channel LED blinker: shared prescaler and PWM counter, a
// valid/ready configuration port, and writes applied on tick boundaries.
module multi_led_blinker
  import led_blink_pkg::*;
#(
  parameter int unsigned NUM_LEDS = 4,
  parameter int unsigned PRESCALE = 100_000,
  parameter int unsigned PERIOD_W = 16,
  parameter int unsigned DUTY_W   = 8,
  localparam int unsigned CHAN_W  = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CHAN_W-1:0]   cfg_chan,
  input  logic [ModeW-1:0]    cfg_mode,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [DUTY_W-1:0]   cfg_duty,
  output logic [NUM_LEDS-1:0] led
);

  localparam int unsigned PrescW = $clog2(PRESCALE);

  logic [PrescW-1:0]   presc_q;
  logic                tick;
  logic [DUTY_W-1:0]   pwm_q;

  cfg_state_t          state_q, state_d;
  logic                ready_q;
  logic                accept;
  logic                apply;

  logic [CHAN_W-1:0]   pend_chan_q;
  led_mode_t           pend_mode_q;
  logic [PERIOD_W-1:0] pend_period_q;
  logic [DUTY_W-1:0]   pend_duty_q;

  logic [NUM_LEDS-1:0] load;
  logic [NUM_LEDS-1:0] led_next;
  logic [NUM_LEDS-1:0] led_q;

  assign tick      = presc_q == PrescW'(PRESCALE - 1);
  assign cfg_ready = ready_q;
  assign led       = led_q;

  // Prescaler and free-running PWM counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      pwm_q   <= '0;
    end else begin
      presc_q <= tick ? '0 : presc_q + PrescW'(1);
      pwm_q   <= pwm_q + DUTY_W'(1);
    end
  end

  // Config FSM: accept one write, then hold it until the next tick.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    apply   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cfg_valid && ready_q) begin
          accept  = 1'b1;
          state_d = StPending;
        end
      end
      StPending: begin
        if (tick) begin
          apply   = 1'b1;
          state_d = StIdle;
        end
      end
    endcase
  end

  // FSM state; ready is registered so it stays low for the whole reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= state_d == StIdle;
    end
  end

  // Pending write registers, captured on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_chan_q   <= '0;
      pend_mode_q   <= ModeOff;
      pend_period_q <= PERIOD_W'(1);
      pend_duty_q   <= '0;
    end else if (accept) begin
      pend_chan_q   <= cfg_chan;
      pend_mode_q   <= led_mode_t'(cfg_mode);
      pend_period_q <= cfg_period;
      pend_duty_q   <= cfg_duty;
    end
  end

  // Out-of-range channel numbers match no channel and are dropped.
  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
    assign load[i] = apply & (pend_chan_q == CHAN_W'(i));

    blink_channel #(
      .PERIOD_W (PERIOD_W),
      .DUTY_W   (DUTY_W)
    ) u_chan (
      .clk_i      (clk),
      .rst_i      (rst),
      .tick_i     (tick),
      .pwm_cnt_i  (pwm_q),
      .load_i     (load[i]),
      .mode_i     (pend_mode_q),
      .period_i   (pend_period_q),
      .duty_i     (pend_duty_q),
      .led_next_o (led_next[i])
    );
  end

  // Registered LED drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q <= '0;
    end else begin
      led_q <= led_next;
    end
  end

endmodule

// File: tb/tb_multi_led_blinker.sv
// Self-checking bench: cycle-accurate behavioural model for the 4-channel
// instance plus directed checks, and a 3-channel instance for range tests.
module tb_multi_led_blinker;

  localparam int P  = 4;
  localparam int NL = 4;
  localparam int DW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_chan = '0;
  logic [1:0]  cfg_mode = '0;
  logic [15:0] cfg_period = '0;
  logic [3:0]  cfg_duty = '0;
  logic [3:0]  led;

  logic        v3 = 1'b0;
  logic        r3;
  logic [1:0]  chan3 = '0;
  logic [1:0]  mode3 = '0;
  logic [15:0] period3 = '0;
  logic [3:0]  duty3 = '0;
  logic [2:0]  led3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  multi_led_blinker #(
    .NUM_LEDS (NL),
    .PRESCALE (P),
    .PERIOD_W (16),
    .DUTY_W   (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_chan   (cfg_chan),
    .cfg_mode   (cfg_mode),
    .cfg_period (cfg_period),
    .cfg_duty   (cfg_duty),
    .led        (led)
  );

  multi_led_blinker #(
    .NUM_LEDS (3),
    .PRESCALE (P),
    .PERIOD_W (16),
    .DUTY_W   (DW)
  ) dut3 (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (v3),
    .cfg_ready  (r3),
    .cfg_chan   (chan3),
    .cfg_mode   (mode3),
    .cfg_period (period3),
    .cfg_duty   (duty3),
    .led        (led3)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of the 4-channel instance ----------
  // Cycle 0 is the first cycle after the last reset edge; in cycle n the
  // prescaler reads n%P and the PWM counter n%16.
  int cyc;
  bit rst_prev = 1'b0;
  bit m_pend;
  int m_pch, m_pmode, m_pper, m_pduty;
  int cur_mode[NL], cur_per[NL], cur_duty[NL], cur_t[NL];
  int prv_mode[NL], prv_per[NL], prv_duty[NL], prv_t[NL];

  always @(posedge clk) rst_prev <= rst;

  // LED value from channel config applied at tick cycle t, seen in state cycle s.
  function automatic bit chan_led(input int mode, input int per, input int duty,
                                  input int t, input int s);
    int k;
    bit ph;
    if (t < 0) return 1'b0;
    k  = ((s - 1 - t) / P) / per;
    ph = (k % 2) == 0;
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return ph;
      default: return ph && ((s % (1 << DW)) < duty);
    endcase
  endfunction

  function automatic logic [NL-1:0] model_led(input int c);
    logic [NL-1:0] r;
    int s;
    r = '0;
    if (c == 0) return r;
    s = c - 1;
    for (int i = 0; i < NL; i++) begin
      if (cur_t[i] >= 0 && s >= cur_t[i] + 1)
        r[i] = chan_led(cur_mode[i], cur_per[i], cur_duty[i], cur_t[i], s);
      else
        r[i] = chan_led(prv_mode[i], prv_per[i], prv_duty[i], prv_t[i], s);
    end
    return r;
  endfunction

  // Compare process: every cycle, DUT outputs against the model.
  always @(negedge clk) begin
    logic [NL-1:0] exp_led;
    bit exp_ready;
    if (rst_prev) begin
      cyc    = 0;
      m_pend = 1'b0;
      for (int i = 0; i < NL; i++) begin
        cur_mode[i] = 0; cur_per[i] = 1; cur_duty[i] = 0; cur_t[i] = -1;
        prv_mode[i] = 0; prv_per[i] = 1; prv_duty[i] = 0; prv_t[i] = -1;
      end
    end
    exp_ready = (cyc >= 1) && !m_pend;
    exp_led   = model_led(cyc);
    check("model_led", int'(led), int'(exp_led));
    check("model_ready", int'(cfg_ready), int'(exp_ready));
    if (!rst) begin
      if (m_pend && (cyc % P) == P - 1) begin
        m_pend = 1'b0;
        if (m_pch < NL) begin
          prv_mode[m_pch] = cur_mode[m_pch]; prv_per[m_pch] = cur_per[m_pch];
          prv_duty[m_pch] = cur_duty[m_pch]; prv_t[m_pch] = cur_t[m_pch];
          cur_mode[m_pch] = m_pmode; cur_per[m_pch] = m_pper;
          cur_duty[m_pch] = m_pduty; cur_t[m_pch] = cyc;
        end
      end
      if (exp_ready && cfg_valid) begin
        m_pend  = 1'b1;
        m_pch   = int'(cfg_chan);
        m_pmode = int'(cfg_mode);
        m_pper  = (cfg_period == 16'd0) ? 1 : int'(cfg_period);
        m_pduty = int'(cfg_duty);
      end
    end
    cyc++;
  end

  // ---------------- stimulus helpers (called at posedge+1) ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
  endtask

  task automatic write4(input int ch, input int mode, input int per, input int duty,
                        output int lows);
    int n;
    bit done;
    n = 0; done = 1'b0; lows = 0;
    cfg_chan = 2'(ch); cfg_mode = 2'(mode); cfg_period = 16'(per); cfg_duty = 4'(duty);
    cfg_valid = 1'b1;
    while (!done && n < 20) begin
      @(negedge clk);
      if (cfg_ready) done = 1'b1;
      else lows++;
      @(posedge clk);
      #1;
      n++;
    end
    cfg_valid = 1'b0;
    check("write_accepted", int'(done), 1);
  endtask

  task automatic write3(input int ch, input int mode);
    int n;
    bit done;
    n = 0; done = 1'b0;
    chan3 = 2'(ch); mode3 = 2'(mode); period3 = 16'd1; duty3 = '0;
    v3 = 1'b1;
    while (!done && n < 20) begin
      @(negedge clk);
      if (r3) done = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    v3 = 1'b0;
    check("write3_accepted", int'(done), 1);
  endtask

  // Waits (bounded) at negedges until led[b]==v.
  task automatic wait_level(input int b, input bit v);
    int n;
    n = 0;
    @(negedge clk);
    while (led[b] !== v && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("blink_edge", int'(led[b]), int'(v));
  endtask

  // Length of the current run of led[b]==v, in cycles (bounded).
  task automatic run_len(input int b, input bit v, output int len);
    len = 0;
    while (led[b] === v && len < 64) begin
      len++;
      @(negedge clk);
    end
  endtask

  // ---------------- directed + random sequence ----------------------------
  initial begin
    int w, len, highs;

    // Reset: 5 clocks held high.
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset_led", int'(led), 0);
    check("reset_ready", int'(cfg_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_cycle0", int'(cfg_ready), 0);
    @(negedge clk);
    check("ready_after_release", int'(cfg_ready), 1);
    @(posedge clk);
    #1;
    wait_cycles(20);
    check("idle_led", int'(led), 0);

    // Blink ch1, period 3: 12 clocks high, 12 low.
    write4(1, 2, 3, 0, w);
    wait_level(1, 1'b1);
    run_len(1, 1'b1, len);
    check("blink_high_len", len, 12);
    run_len(1, 1'b0, len);
    check("blink_low_len", len, 12);
    @(posedge clk);
    #1;

    // Period 0 behaves as period 1.
    write4(0, 2, 0, 0, w);
    wait_level(0, 1'b1);
    run_len(0, 1'b1, len);
    check("p0_high_len", len, 4);
    run_len(0, 1'b0, len);
    check("p0_low_len", len, 4);
    @(posedge clk);
    #1;

    // Back-to-back writes with valid held high.
    write4(0, 1, 1, 0, w);
    write4(3, 1, 1, 0, w);
    check("hs_second_blocked", int'(w >= 1), 1);
    check("hs_ready_low_le5", int'(w <= 5), 1);
    wait_cycles(8);
    check("hs_ch0_on", int'(led[0]), 1);
    check("hs_ch3_on", int'(led[3]), 1);

    // Dimmed blink aligned so the high phase covers PWM counts 12..3.
    do_reset();
    wait_cycles(8);
    write4(2, 3, 2, 4, w);
    highs = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (led[2]) highs++;
    end
    check("dim_high_count", highs, 16);
    @(posedge clk);
    #1;

    // Out-of-range channel on the 3-channel instance is dropped.
    write3(3, 1);
    wait_cycles(12);
    check("oor_led3", int'(led3), 0);
    check("oor_ready_recovers", int'(r3), 1);
    write3(2, 1);
    wait_cycles(12);
    check("inrange_led3", int'(led3), 4);

    // Reset while a write is pending discards it.
    write4(3, 1, 1, 0, w);
    do_reset();
    wait_cycles(24);
    check("rst_pending_led", int'(led), 0);

    // Random writes against the model.
    for (int k = 0; k < 40; k++) begin
      write4(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), w);
      wait_cycles(int'($urandom_range(0, 6)));
    end
    wait_cycles(40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
